loop_buffer_sync: RTL and testbench
===================================

Name: loop_buffer_sync

Overview:
- Synchronous packet ring buffer: one RAM divided into 2^(LOOP_WIDTH-WADDR_WIDTH) equal slots, each 2^WADDR_WIDTH words.
- The writer fills the current slot at caller-supplied offsets and commits it with a last flag. The reader randomly addresses the oldest committed slot, then releases it.
- Sits between a streaming producer (e.g. a CPRI symbol writer) and a consumer that must re-read whole symbols.

Parameters:
- WDATA_WIDTH, 64: write data width.
- WADDR_WIDTH, 12: word-offset width inside a slot.
- RDATA_WIDTH, 64: read data width; must equal WDATA_WIDTH.
- RADDR_WIDTH, 12: read offset width; must equal WADDR_WIDTH.
- READ_LATENCY, 3: clocks from rd_addr sample to rd_data; legal range 1..4.
- FIFO_DEPTH, 8: depth of the per-packet info FIFO; must be >= number of slots.
- FIFO_WIDTH, 1: reserved; accepted, no functional effect.
- LOOP_WIDTH, 15: total RAM address width; SLOTS = 2^(LOOP_WIDTH-WADDR_WIDTH).
- INFO_WIDTH, 1: width of per-packet sideband info.
- RAM_TYPE, 1: 1 = block RAM, 0 = distributed/LUT RAM; must not change cycle behaviour.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- syn_rst  in  1  reset, synchronous, active-high.
- wr_wen  in  1  write strobe.
- wr_addr  in  WADDR_WIDTH  word offset inside the current write slot.
- wr_data  in  WDATA_WIDTH  write data.
- wr_wlast  in  1  with wr_wen: last word of packet; commits the slot.
- wr_info  in  INFO_WIDTH  packet sideband info, accumulated by OR over the packet.
- free_size  out  LOOP_WIDTH-WADDR_WIDTH+1  number of uncommitted slots (0..SLOTS).
- rd_addr  in  RADDR_WIDTH  word offset inside the head (oldest committed) slot.
- rd_data  out  RDATA_WIDTH  read data.
- rd_vld  out  1  at least one committed slot is available.
- rd_info  out  INFO_WIDTH  info of the head packet; valid while rd_vld=1.
- rd_rdy  in  1  one-cycle pulse: release the head slot.

Behaviour:
- State: wr_slot and rd_slot pointers, each LOOP_WIDTH-WADDR_WIDTH bits, wrapping modulo SLOTS.
- State: used count, 0..SLOTS.
- State: info accumulator, and info FIFO of FIFO_DEPTH entries.
- Reset (syn_rst=1 at an edge): pointers=0, used=0, accumulator=0, FIFO empty. Outputs become free_size=SLOTS, rd_vld=0, rd_info=0.
- Reset does not clear RAM contents. rd_data is don't-care until a valid read.
- Reset mid-packet discards the partial packet and all committed packets.
- Write: wr_wen=1 and used<SLOTS writes wr_data to RAM[{wr_slot,wr_addr}]. wr_addr is free; no sequential order is required.
- Each accepted write ORs wr_info into the accumulator.
- Commit: an accepted write with wr_wlast=1 pushes (accumulator | wr_info) to the info FIFO, clears the accumulator, increments wr_slot and increments used.
- Full: when used==SLOTS, wr_wen is ignored. No RAM write, no commit, no accumulator change.
- free_size = SLOTS-used; rd_vld = (used!=0). Both are registered state, so they update on the edge after a commit or release.
- Read: RAM address {rd_slot,rd_addr} is sampled every cycle, unqualified by rd_vld. rd_data presents that word exactly READ_LATENCY clocks later, pipelined, one result per clock.
- A read of the slot currently being written returns the stored RAM content. There is no write-to-read bypass.
- Release: rd_rdy=1 with used!=0 increments rd_slot, decrements used and pops the info FIFO. rd_rdy with used==0 is ignored.
- Reads already in the pipeline when rd_rdy occurs complete from the old slot. Addresses sampled after the edge target the new head slot.
- Commit and release in the same cycle: used is unchanged, both pointers advance, and the FIFO pushes and pops together.
- rd_info is the info FIFO head (first-word-fall-through) and tracks rd_slot.
- Pointer wrap: slot SLOTS-1 advances to slot 0.

Test Plan:
- Reset, then idle -> free_size=8, rd_vld=0, rd_info=0.
- Write slot 0 at offsets 0..3167 (data=offset) with wr_info=1 at offset 1 and wr_wlast at 3167 -> rd_vld=1 next cycle, free_size=7, rd_info=1. rd_addr=k gives rd_data=k exactly 3 clocks later for k=0..3167 back-to-back.
- Write 8 packets without releasing -> free_size=0. A 9th write burst is dropped, so slot 0 data is unchanged.
- Pulse rd_rdy -> free_size=1, and the next read targets slot 1 data.
- Commit packet N+1 and pulse rd_rdy in the same cycle -> used and free_size unchanged, rd_info advances to the next packet.
- Write and release 20 packets -> pointers wrap past slot 7, and data/info order is preserved (packet id in data MSBs checked).
- Assert syn_rst mid-packet with 3 packets committed -> free_size=8 and rd_vld=0 next cycle. The next packet lands in slot 0.

Source files
------------

// File: rtl/loop_buffer_sync.sv
// loop_buffer_sync: slotted packet ring buffer with an info FIFO.
// Writer fills and commits slots; reader random-reads the oldest slot.
module loop_buffer_sync #(
    parameter int WDATA_WIDTH  = 64,
    parameter int WADDR_WIDTH  = 12,
    parameter int RDATA_WIDTH  = 64,
    parameter int RADDR_WIDTH  = 12,
    parameter int READ_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_WIDTH   = 1,
    parameter int LOOP_WIDTH   = 15,
    parameter int INFO_WIDTH   = 1,
    parameter int RAM_TYPE     = 1
) (
    input  logic                               clk,
    input  logic                               syn_rst,
    input  logic                               wr_wen,
    input  logic [WADDR_WIDTH-1:0]             wr_addr,
    input  logic [WDATA_WIDTH-1:0]             wr_data,
    input  logic                               wr_wlast,
    input  logic [INFO_WIDTH-1:0]              wr_info,
    output logic [LOOP_WIDTH-WADDR_WIDTH:0]    free_size,
    input  logic [RADDR_WIDTH-1:0]             rd_addr,
    output logic [RDATA_WIDTH-1:0]             rd_data,
    output logic                               rd_vld,
    output logic [INFO_WIDTH-1:0]              rd_info,
    input  logic                               rd_rdy
);

    localparam int SW    = LOOP_WIDTH - WADDR_WIDTH;
    localparam int SLOTS = 2 ** SW;
    localparam int FW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [SW:0]   SLOTS_N = SLOTS[SW:0];
    localparam logic [FW-1:0] F_LAST  = FW'(FIFO_DEPTH - 1);

    // Reject parameter sets the datapath cannot honour.
    if (RDATA_WIDTH != WDATA_WIDTH || RADDR_WIDTH != WADDR_WIDTH ||
        READ_LATENCY < 1 || READ_LATENCY > 4 ||
        FIFO_DEPTH < SLOTS || FIFO_WIDTH < 0) begin : g_bad_params
        $error("loop_buffer_sync: illegal parameter combination");
    end

    logic [SW-1:0]         wr_slot;
    logic [SW-1:0]         rd_slot;
    logic [SW:0]           used;
    logic [INFO_WIDTH-1:0] acc;
    logic [INFO_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [FW-1:0]         f_head;
    logic [FW-1:0]         f_tail;
    logic                  accept;
    logic                  commit;
    logic                  rel;
    logic [LOOP_WIDTH-1:0] waddr;
    logic [LOOP_WIDTH-1:0] raddr;
    logic [RDATA_WIDTH-1:0] ram_q;

    function automatic logic [FW-1:0] f_next(input logic [FW-1:0] p);
        return (p == F_LAST) ? '0 : p + 1'b1;
    endfunction

    assign accept = wr_wen && (used != SLOTS_N);
    assign commit = accept && wr_wlast;
    assign rel    = rd_rdy && (used != '0);
    assign waddr  = {wr_slot, wr_addr};
    assign raddr  = {rd_slot, rd_addr};

    assign free_size = SLOTS_N - used;
    assign rd_vld    = (used != '0);
    assign rd_info   = rd_vld ? fifo[f_head] : '0;

    // Slot pointers, occupancy, info accumulator and FIFO pointers.
    always_ff @(posedge clk) begin
        if (syn_rst) begin
            wr_slot <= '0;
            rd_slot <= '0;
            used    <= '0;
            acc     <= '0;
            f_head  <= '0;
            f_tail  <= '0;
        end else begin
            if (accept) begin
                acc <= commit ? '0 : (acc | wr_info);
            end
            if (commit) begin
                wr_slot <= wr_slot + 1'b1;
                f_tail  <= f_next(f_tail);
            end
            if (rel) begin
                rd_slot <= rd_slot + 1'b1;
                f_head  <= f_next(f_head);
            end
            case ({commit, rel})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

    // Info FIFO storage; the committed word carries its own wr_info too.
    always_ff @(posedge clk) begin
        if (!syn_rst && commit) begin
            fifo[f_tail] <= acc | wr_info;
        end
    end

    if (RAM_TYPE == 1) begin : g_bram
        (* ram_style = "block" *)
        logic [WDATA_WIDTH-1:0] mem [2 ** LOOP_WIDTH];

        // Read-first RAM: same-edge writes are not bypassed to reads.
        always_ff @(posedge clk) begin
            if (accept) begin
                mem[waddr] <= wr_data;
            end
            ram_q <= mem[raddr];
        end
    end else begin : g_lutram
        (* ram_style = "distributed" *)
        logic [WDATA_WIDTH-1:0] mem [2 ** LOOP_WIDTH];

        // Registered read keeps timing identical to the block RAM variant.
        always_ff @(posedge clk) begin
            if (accept) begin
                mem[waddr] <= wr_data;
            end
            ram_q <= mem[raddr];
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_data = ram_q;
    end else begin : g_latn
        logic [RDATA_WIDTH-1:0] pipe [READ_LATENCY-1];

        // Extra output stages to reach the configured read latency.
        always_ff @(posedge clk) begin
            pipe[0] <= ram_q;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        assign rd_data = pipe[READ_LATENCY-2];
    end

endmodule

// File: tb/tb_loop_buffer_sync.sv
// tb_loop_buffer_sync: directed bench for loop_buffer_sync.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_loop_buffer_sync;

    logic        clk = 1'b0;
    logic        syn_rst;
    logic        wr_wen;
    logic [11:0] wr_addr;
    logic [63:0] wr_data;
    logic        wr_wlast;
    logic [0:0]  wr_info;
    logic [3:0]  free_size;
    logic [11:0] rd_addr;
    logic [63:0] rd_data;
    logic        rd_vld;
    logic [0:0]  rd_info;
    logic        rd_rdy;

    int checks   = 0;
    int failures = 0;
    int q[$];
    logic [63:0] d;

    always #5 clk = ~clk;

    loop_buffer_sync dut (
        .clk       (clk),
        .syn_rst   (syn_rst),
        .wr_wen    (wr_wen),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_wlast  (wr_wlast),
        .wr_info   (wr_info),
        .free_size (free_size),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rd_info   (rd_info),
        .rd_rdy    (rd_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input int off, input logic [63:0] data,
                              input bit last, input bit info);
        wr_wen   = 1'b1;
        wr_addr  = 12'(off);
        wr_data  = data;
        wr_wlast = last;
        wr_info  = info;
        @(negedge clk);
        wr_wen   = 1'b0;
        wr_wlast = 1'b0;
        wr_info  = 1'b0;
    endtask

    function automatic logic [63:0] pkt_word(input int id, input int off);
        return (64'(id) << 48) | 64'(off);
    endfunction

    // Four-word packet, info raised only on offset 2, written out of order.
    task automatic write_pkt(input int id, input bit info);
        write_word(2, pkt_word(id, 2), 1'b0, info);
        write_word(0, pkt_word(id, 0), 1'b0, 1'b0);
        write_word(1, pkt_word(id, 1), 1'b0, 1'b0);
        write_word(3, pkt_word(id, 3), 1'b1, 1'b0);
    endtask

    task automatic rd(input int a, output logic [63:0] data);
        rd_addr = 12'(a);
        repeat (3) @(negedge clk);
        data = rd_data;
    endtask

    task automatic release_head();
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
    endtask

    initial begin
        syn_rst  = 1'b1;
        wr_wen   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_wlast = 1'b0;
        wr_info  = 1'b0;
        rd_addr  = '0;
        rd_rdy   = 1'b0;
        repeat (2) @(negedge clk);
        syn_rst = 1'b0;
        @(negedge clk);

        check("rst_free", 64'(free_size), 64'd8);
        check("rst_vld",  64'(rd_vld),    64'd0);
        check("rst_info", 64'(rd_info),   64'd0);

        // Packet 0: 3168 words, data = offset, info only at offset 1.
        for (int k = 0; k < 3168; k++) begin
            write_word(k, 64'(k), k == 3167, k == 1);
        end
        q.push_back(0);
        check("p0_vld",  64'(rd_vld),    64'd1);
        check("p0_free", 64'(free_size), 64'd7);
        check("p0_info", 64'(rd_info),   64'd1);

        for (int k = 0; k < 3168 + 3; k++) begin
            if (k >= 3) check("b2b_rd", rd_data, 64'(k - 3));
            if (k < 3168) rd_addr = 12'(k);
            @(negedge clk);
        end

        // Fill the remaining seven slots.
        for (int p = 1; p < 8; p++) begin
            write_pkt(p, p[0]);
            q.push_back(p);
        end
        check("full_free", 64'(free_size), 64'd0);

        // Burst while full targets slot 0 again but must be dropped.
        for (int k = 0; k < 4; k++) begin
            write_word(k, 64'hDEAD_0000_0000_0000 | 64'(k), k == 3, 1'b1);
        end
        check("drop_free", 64'(free_size), 64'd0);
        check("drop_vld",  64'(rd_vld),    64'd1);
        rd(1, d);
        check("drop_rd1", d, 64'd1);
        rd(3, d);
        check("drop_rd3", d, 64'd3);

        release_head();
        void'(q.pop_front());
        check("rel_free", 64'(free_size), 64'd1);
        check("rel_info", 64'(rd_info),   64'd1);
        rd(2, d);
        check("rel_rd", d, pkt_word(1, 2));

        // Commit packet 8 and release packet 1 on the same edge.
        write_word(0, pkt_word(8, 0), 1'b0, 1'b0);
        write_word(1, pkt_word(8, 1), 1'b0, 1'b0);
        write_word(2, pkt_word(8, 2), 1'b0, 1'b0);
        rd_rdy = 1'b1;
        write_word(3, pkt_word(8, 3), 1'b1, 1'b0);
        rd_rdy = 1'b0;
        q.push_back(8);
        void'(q.pop_front());
        check("both_free", 64'(free_size), 64'd1);
        check("both_vld",  64'(rd_vld),    64'd1);
        check("both_info", 64'(rd_info),   64'd0);
        rd(3, d);
        check("both_rd", d, pkt_word(2, 3));

        // Stream 20 packets through, wrapping both pointers.
        for (int p = 9; p < 29; p++) begin
            write_pkt(p, p[0]);
            q.push_back(p);
            check("wrap_free", 64'(free_size), 64'd0);
            rd(1, d);
            check("wrap_rd", d, pkt_word(q[0], 1));
            check("wrap_info", 64'(rd_info), 64'(q[0] & 1));
            release_head();
            void'(q.pop_front());
        end

        // Drain to three committed packets, then reset mid-packet.
        repeat (4) begin
            release_head();
            void'(q.pop_front());
        end
        check("drain_free", 64'(free_size), 64'd5);
        rd(0, d);
        check("drain_rd", d, pkt_word(q[0], 0));
        write_word(0, pkt_word(50, 0), 1'b0, 1'b1);
        write_word(1, pkt_word(50, 1), 1'b0, 1'b0);
        syn_rst = 1'b1;
        @(negedge clk);
        syn_rst = 1'b0;
        check("mrst_free", 64'(free_size), 64'd8);
        check("mrst_vld",  64'(rd_vld),    64'd0);
        check("mrst_info", 64'(rd_info),   64'd0);

        release_head();
        check("empty_rel_free", 64'(free_size), 64'd8);
        check("empty_rel_vld",  64'(rd_vld),    64'd0);

        write_pkt(99, 1'b1);
        check("post_free", 64'(free_size), 64'd7);
        check("post_info", 64'(rd_info),   64'd1);
        rd(0, d);
        check("post_rd0", d, pkt_word(99, 0));
        rd(3, d);
        check("post_rd3", d, pkt_word(99, 3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
